cut_stimulus_sequencer: RTL and testbench

Automated stimulus/response engine for the evolved-circuit test bench. It replaces manual switch setting with a clocked sweep of the 5-bit data inputs of a selected circuit-under-test (CUT), and drives the 10-bit stimulus bus (select in [9:5], data in [4:0]) that the 32-way CUT array and output mux consume. It reads back the muxed CUT output once per step and packs the responses into a 32-bit signature plus a ones count for display/readout.

---
 rtl/cut_stimulus_sequencer.sv | 144 ++++++++++++++
 tb/tb_cut_stimulus_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cut_stimulus_sequencer.sv
// Clocked stimulus sweep for the evolved-circuit CUT array.
// Drives {sel, pattern}, samples the muxed response, packs a signature.
module cut_stimulus_sequencer #(
  parameter int         SETTLE_CYCLES = 8,
  parameter logic [4:0] LFSR_SEED     = 5'b00001
) (
  input  logic        CLOCK_50,
  input  logic        RESET,
  input  logic        START,
  input  logic        MODE,
  input  logic [4:0]  CIRCUIT_SEL,
  input  logic [5:0]  NUM_STEPS,
  input  logic        CUT_OUT,
  output logic [9:0]  STIM,
  output logic        BUSY,
  output logic        DONE,
  output logic [31:0] SIGNATURE,
  output logic [5:0]  ONES
);

  localparam logic [7:0] WRELOAD = 8'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [4:0]  sel;
  logic [5:0]  nsteps;
  logic        mode;
  logic [4:0]  pat;
  logic [4:0]  step;
  logic [7:0]  wcnt;
  logic [31:0] sig;
  logic [5:0]  ones;
  logic        sync1;
  logic        cut_s;

  logic        start_ok;
  logic        sample;
  logic        last;
  logic [4:0]  pat_adv;
  logic [4:0]  pat0;
  logic [5:0]  nsteps_in;

  assign start_ok = (state == IDLE) && START;
  assign sample   = (state == SETTLE) && (wcnt == 8'd0);
  assign last     = sample && ({1'b0, step} == (nsteps - 6'd1));

  // next pattern: binary count or 5-bit maximal-length LFSR
  assign pat_adv  = mode ? {pat[3:0], pat[4] ^ pat[2]}
                         : pat + 5'd1;
  assign pat0     = MODE ? LFSR_SEED : 5'd0;

  // zero (and any out-of-range count) selects the full 32-step sweep
  assign nsteps_in = ((NUM_STEPS == 6'd0) || (NUM_STEPS > 6'd32))
                   ? 6'd32 : NUM_STEPS;

  // state register
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (START) state_nxt = SETTLE;
      SETTLE:  if (last)  state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // status outputs decoded from state
  always_comb begin
    BUSY = 1'b0;
    DONE = 1'b0;
    unique case (state)
      SETTLE:  BUSY = 1'b1;
      FINISH:  DONE = 1'b1;
      default: ;
    endcase
  end

  // two-flop synchroniser for the asynchronous CUT response
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      sync1 <= 1'b0;
      cut_s <= 1'b0;
    end else begin
      sync1 <= CUT_OUT;
      cut_s <= sync1;
    end
  end

  // run datapath: launch, settle countdown, sample and advance
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      sel    <= 5'd0;
      nsteps <= 6'd32;
      mode   <= 1'b0;
      pat    <= 5'd0;
      step   <= 5'd0;
      wcnt   <= 8'd0;
      sig    <= 32'd0;
      ones   <= 6'd0;
    end else if (start_ok) begin
      sel    <= CIRCUIT_SEL;
      nsteps <= nsteps_in;
      mode   <= MODE;
      pat    <= pat0;
      step   <= 5'd0;
      wcnt   <= WRELOAD;
      sig    <= 32'd0;
      ones   <= 6'd0;
    end else if (state == SETTLE) begin
      if (!sample) begin
        wcnt <= wcnt - 8'd1;
      end else begin
        sig  <= {sig[30:0], cut_s};
        ones <= ones + {5'd0, cut_s};
        if (!last) begin
          pat  <= pat_adv;
          step <= step + 5'd1;
          wcnt <= WRELOAD;
        end
      end
    end
  end

  assign STIM      = {sel, pat};
  assign SIGNATURE = sig;
  assign ONES      = ones;

endmodule

// File: tb/tb_cut_stimulus_sequencer.sv
// Scoreboard bench for cut_stimulus_sequencer.
// Stimulus pushes expected runs; a negedge monitor checks on DONE.
module tb_cut_stimulus_sequencer;

  localparam int S = 8;

  logic        CLOCK_50 = 1'b0;
  logic        RESET    = 1'b1;
  logic        START    = 1'b0;
  logic        MODE     = 1'b0;
  logic [4:0]  CIRCUIT_SEL = 5'd0;
  logic [5:0]  NUM_STEPS   = 6'd0;
  logic        CUT_OUT;
  logic [9:0]  STIM;
  logic        BUSY;
  logic        DONE;
  logic [31:0] SIGNATURE;
  logic [5:0]  ONES;

  cut_stimulus_sequencer #(
    .SETTLE_CYCLES(S),
    .LFSR_SEED(5'b00001)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .RESET(RESET),
    .START(START),
    .MODE(MODE),
    .CIRCUIT_SEL(CIRCUIT_SEL),
    .NUM_STEPS(NUM_STEPS),
    .CUT_OUT(CUT_OUT),
    .STIM(STIM),
    .BUSY(BUSY),
    .DONE(DONE),
    .SIGNATURE(SIGNATURE),
    .ONES(ONES)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // CUT model: response selected per test, optional async noise
  logic [1:0] cut_mode = 2'd0;
  logic       noise = 1'b0;
  int         age = 0;
  logic [9:0] prev_stim = 10'd0;

  always #3 noise = ~noise;

  always @(negedge CLOCK_50) begin
    if (STIM != prev_stim) age = 0;
    else age = age + 1;
    prev_stim = STIM;
  end

  always_comb begin
    CUT_OUT = 1'b0;
    case (cut_mode)
      2'd0: CUT_OUT = STIM[0];
      2'd1: CUT_OUT = 1'b1;
      2'd2: CUT_OUT = STIM[4];
      default: CUT_OUT = STIM[1] ^ ((age < S - 4) ? noise : 1'b0);
    endcase
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0]  sig;
    logic [5:0]   ones;
    logic [4:0]   sel;
    logic [5:0]   n;
    logic [31:0]  c0;
    logic [159:0] pats;
  } exp_t;

  exp_t q[$];

  function automatic logic [159:0] mkpats(bit m, int n);
    logic [159:0] r;
    logic [4:0]   p;
    r = '0;
    p = m ? 5'h01 : 5'h00;
    for (int i = 0; i < n; i++) begin
      r[i*5 +: 5] = p;
      p = m ? {p[3:0], p[4] ^ p[2]} : p + 5'd1;
    end
    return r;
  endfunction

  // monitor
  logic [4:0] obs [32];
  logic [4:0] last_obs [32];
  int         nobs = 0;
  int         last_nobs = 0;
  logic [4:0] lastp = 5'd0;
  bit         selbad = 0;
  logic       busy_d = 1'b0;
  int         done_cnt = 0;

  always @(negedge CLOCK_50) begin
    exp_t e;
    bit   bad;
    if (BUSY && !busy_d) begin
      nobs = 0;
      selbad = 0;
    end
    if (BUSY) begin
      if (!busy_d || STIM[4:0] != lastp) begin
        if (nobs < 32) obs[nobs] = STIM[4:0];
        nobs++;
        lastp = STIM[4:0];
      end
      if (q.size() > 0 && STIM[9:5] != q[0].sel) selbad = 1;
    end
    if (DONE) begin
      done_cnt++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done_unexpected actual=1 expected=0");
      end else begin
        e = q.pop_front();
        chk("signature", SIGNATURE, e.sig);
        chk("ones", 32'(ONES), 32'(e.ones));
        chk("latency", 32'(cyc - int'(e.c0) + 1),
            32'(int'(e.n) * S + 1));
        chk("busy_at_done", 32'(BUSY), 32'd0);
        chk("steps", 32'(nobs), 32'(e.n));
        bad = 0;
        for (int i = 0; i < int'(e.n); i++)
          if (i >= nobs || obs[i] != e.pats[i*5 +: 5]) bad = 1;
        chk("pattern_seq", 32'(bad), 32'd0);
        chk("sel_stable", 32'(selbad), 32'd0);
        chk("stim_sel", 32'(STIM[9:5]), 32'(e.sel));
        last_nobs = nobs;
        for (int i = 0; i < 32; i++) last_obs[i] = obs[i];
      end
    end
    busy_d = BUSY;
  end

  // stimulus
  task automatic issue(bit m, logic [4:0] s, logic [5:0] ns,
                       logic [1:0] cm, logic [31:0] sg,
                       logic [5:0] on);
    exp_t e;
    int   n;
    n = (ns == 6'd0) ? 32 : int'(ns);
    @(negedge CLOCK_50);
    cut_mode    = cm;
    MODE        = m;
    CIRCUIT_SEL = s;
    NUM_STEPS   = ns;
    START       = 1'b1;
    @(posedge CLOCK_50);
    #1;
    START  = 1'b0;
    e.sig  = sg;
    e.ones = on;
    e.sel  = s;
    e.n    = 6'(n);
    e.c0   = 32'(cyc);
    e.pats = mkpats(m, n);
    q.push_back(e);
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (q.size() != 0 && k < 3000) begin
      @(posedge CLOCK_50);
      k++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=%0d expected=0", q.size());
      q.delete();
    end
    repeat (2) @(posedge CLOCK_50);
  endtask

  initial begin
    logic [4:0]  hand [5];
    logic [31:0] seen;
    logic [31:0] lsig;
    logic [5:0]  lones;
    logic [4:0]  p;
    int          dc;

    hand[0] = 5'h01;
    hand[1] = 5'h02;
    hand[2] = 5'h04;
    hand[3] = 5'h09;
    hand[4] = 5'h12;

    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    chk("rst_stim", 32'(STIM), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_sig", SIGNATURE, 32'd0);
    chk("rst_ones", 32'(ONES), 32'd0);
    RESET = 1'b0;

    // binary sweep, response = bit 0
    issue(1'b0, 5'h15, 6'd8, 2'd0, 32'h0000_0055, 6'd4);
    wait_done();

    // full 32-step sweep, response tied high
    issue(1'b0, 5'h03, 6'd0, 2'd1, 32'hFFFF_FFFF, 6'd32);
    wait_done();

    // LFSR sweep over all non-zero patterns, response = bit 4
    p = 5'h01;
    lsig = 32'd0;
    lones = 6'd0;
    for (int i = 0; i < 31; i++) begin
      lsig = {lsig[30:0], p[4]};
      lones = lones + {5'd0, p[4]};
      p = {p[3:0], p[4] ^ p[2]};
    end
    issue(1'b1, 5'h1F, 6'd31, 2'd2, lsig, 6'd16);
    wait_done();
    for (int i = 0; i < 5; i++)
      chk("lfsr_head", 32'(last_obs[i]), 32'(hand[i]));
    seen = 32'd0;
    for (int i = 0; i < last_nobs && i < 32; i++)
      seen[last_obs[i]] = 1'b1;
    chk("lfsr_cover", seen, 32'hFFFF_FFFE);

    // START mid-run with another selection is ignored
    issue(1'b0, 5'h07, 6'd8, 2'd0, 32'h0000_0055, 6'd4);
    repeat (20) @(negedge CLOCK_50);
    CIRCUIT_SEL = 5'h18;
    MODE        = 1'b1;
    NUM_STEPS   = 6'd3;
    START       = 1'b1;
    @(negedge CLOCK_50);
    START = 1'b0;
    wait_done();

    // noisy early response, stable for the last three clocks
    issue(1'b0, 5'h11, 6'd8, 2'd3, 32'h0000_0033, 6'd4);
    wait_done();

    // reset during the third step aborts with no DONE
    issue(1'b0, 5'h0A, 6'd8, 2'd0, 32'h0000_0055, 6'd4);
    repeat (2 * S + 3) @(negedge CLOCK_50);
    RESET = 1'b1;
    @(negedge CLOCK_50);
    chk("abort_stim", 32'(STIM), 32'd0);
    chk("abort_busy", 32'(BUSY), 32'd0);
    chk("abort_sig", SIGNATURE, 32'd0);
    chk("abort_ones", 32'(ONES), 32'd0);
    q.delete();
    dc = done_cnt;
    RESET = 1'b0;
    repeat (100) @(negedge CLOCK_50);
    chk("abort_no_done", 32'(done_cnt), 32'(dc));

    // normal run after the abort
    issue(1'b0, 5'h0A, 6'd8, 2'd0, 32'h0000_0055, 6'd4);
    wait_done();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
